// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory, its arbiter and the instruction controller.
// Holds the owner encoding and the default data/address widths.
package dmem_pkg;

    localparam int DMEM_WIDTH   = 16;
    localparam int DMEM_ADDR_W  = 8;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } owner_t;

    function automatic owner_t grant_owner(input logic cpu_gnt, input logic dbg_gnt);
        if (cpu_gnt) begin
            return CPU;
        end else if (dbg_gnt) begin
            return DBG;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating starvation counter for the debug port of dmem_arbiter.
// Clear has priority over increment; o_at_max flags the STARVE_MAX threshold.
module starve_counter
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_max
);

    localparam logic [STARVE_CNT_W-1:0] MAX_VAL = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == MAX_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, debug) arbiter for the single-port synchronous data memory.
// Optional feature: define DMEM_ARB_LOCK_EN to add the dbg_lock bulk-load input.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH      = DMEM_WIDTH,
    parameter int D_ADDR_W   = DMEM_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_req,
    input  logic                cpu_wr,
    input  logic [D_ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]    cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [WIDTH-1:0]    cpu_rdata,
    input  logic                dbg_req,
    input  logic                dbg_wr,
    input  logic [D_ADDR_W-1:0] dbg_addr,
    input  logic [WIDTH-1:0]    dbg_wdata,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [WIDTH-1:0]    dbg_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                dbg_lock,
`endif
    output logic [D_ADDR_W-1:0] mem_addr,
    output logic                mem_wr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic [1:0]          owner
);

    // Handshake: a requester holds req/wr/addr/wdata stable until it samples
    // its gnt high at a rising edge; that edge completes the access. Reads
    // return one cycle later with *_rvalid high for exactly one cycle.

    logic                w_lock;
    logic                w_at_max;
    logic                w_dbg_wins;
    logic                w_cpu_gnt;
    logic                w_dbg_gnt;
    logic [D_ADDR_W-1:0] w_mem_addr;
    logic [WIDTH-1:0]    w_mem_wdata;
    logic                w_mem_wr;

    logic [D_ADDR_W-1:0] r_last_addr;
    owner_t              r_owner;
    owner_t              r_tag;

`ifdef DMEM_ARB_LOCK_EN
    assign w_lock = dbg_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Debug takes the cycle when alone, when starved out, or while locked.
    assign w_dbg_wins = dbg_req && (w_lock || !cpu_req || w_at_max);
    assign w_dbg_gnt  = reset_n && w_dbg_wins;
    assign w_cpu_gnt  = reset_n && cpu_req && !w_dbg_wins && !w_lock;

    starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_dbg_gnt || !dbg_req || w_lock),
        .i_inc   (dbg_req && !w_dbg_gnt),
        .o_at_max(w_at_max)
    );

    always_comb begin
        w_mem_addr  = r_last_addr;
        w_mem_wdata = cpu_wdata;
        w_mem_wr    = 1'b0;
        if (w_cpu_gnt) begin
            w_mem_addr  = cpu_addr;
            w_mem_wdata = cpu_wdata;
            w_mem_wr    = cpu_wr;
        end else if (w_dbg_gnt) begin
            w_mem_addr  = dbg_addr;
            w_mem_wdata = dbg_wdata;
            w_mem_wr    = dbg_wr;
        end
    end

    // The tag remembers which port a read belongs to so the returning data
    // is flagged on the right rvalid; an async reset drops it outright.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_addr <= '0;
            r_owner     <= NONE;
            r_tag       <= NONE;
        end else begin
            r_last_addr <= w_mem_addr;
            r_owner     <= grant_owner(w_cpu_gnt, w_dbg_gnt);
            r_tag       <= grant_owner(w_cpu_gnt && !cpu_wr, w_dbg_gnt && !dbg_wr);
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign mem_addr   = w_mem_addr;
    assign mem_wdata  = w_mem_wdata;
    assign mem_wr     = w_mem_wr;
    assign cpu_rvalid = (r_tag == CPU);
    assign dbg_rvalid = (r_tag == DBG);
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;
    assign owner      = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases from the test plan plus a randomized
// phase, all checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int WIDTH      = 16;
    localparam int D_ADDR_W   = 8;
    localparam int STARVE_MAX = 4;

    logic                clk;
    logic                reset_n;
    logic                cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
    logic [D_ADDR_W-1:0] cpu_addr;
    logic [WIDTH-1:0]    cpu_wdata, cpu_rdata;
    logic                dbg_req, dbg_wr, dbg_gnt, dbg_rvalid;
    logic [D_ADDR_W-1:0] dbg_addr;
    logic [WIDTH-1:0]    dbg_wdata, dbg_rdata;
    logic                dbg_lock;
    logic [D_ADDR_W-1:0] mem_addr;
    logic                mem_wr;
    logic [WIDTH-1:0]    mem_wdata, mem_rdata;
    logic [1:0]          owner;

    dmem_arbiter #(
        .WIDTH(WIDTH), .D_ADDR_W(D_ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
`ifdef DMEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment memory ----------------
    logic [WIDTH-1:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_wr) env_mem[mem_addr] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [WIDTH-1:0] ref_mem [256];
    logic [WIDTH-1:0] exp_q [$];
    int               m_denied;
    int               m_owner;
    int               m_tag;
    logic [D_ADDR_W-1:0] m_last;
    bit               g_cpu, g_dbg;
    int               total, bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle_check();
        bit e_cpu, e_dbg, e_wr;
        logic [D_ADDR_W-1:0] e_addr;
        logic [WIDTH-1:0]    e_wdata;
        logic [WIDTH-1:0]    d;
        @(negedge clk);
        if (!reset_n) begin
            chk("rst_cpu_gnt", cpu_gnt, 0);
            chk("rst_dbg_gnt", dbg_gnt, 0);
            chk("rst_mem_wr", mem_wr, 0);
            chk("rst_owner", owner, 0);
            chk("rst_cpu_rvalid", cpu_rvalid, 0);
            chk("rst_dbg_rvalid", dbg_rvalid, 0);
            m_denied = 0; m_owner = 0; m_tag = 0; m_last = '0;
            exp_q.delete();
            g_cpu = 0; g_dbg = 0;
            return;
        end
        e_dbg = dbg_req && (dbg_lock || !cpu_req || m_denied >= STARVE_MAX);
        e_cpu = cpu_req && !e_dbg && !dbg_lock;
        e_addr  = e_cpu ? cpu_addr  : (e_dbg ? dbg_addr  : m_last);
        e_wdata = e_cpu ? cpu_wdata : dbg_wdata;
        e_wr    = (e_cpu && cpu_wr) || (e_dbg && dbg_wr);
        chk("cpu_gnt", cpu_gnt, e_cpu);
        chk("dbg_gnt", dbg_gnt, e_dbg);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
        chk("owner", owner, m_owner);
        chk("cpu_rvalid", cpu_rvalid, m_tag == 1);
        chk("dbg_rvalid", dbg_rvalid, m_tag == 2);
        if (m_tag != 0) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_empty", 1, 0);
            end else begin
                d = exp_q.pop_front();
                if (m_tag == 1) chk("cpu_rdata", cpu_rdata, d);
                else            chk("dbg_rdata", dbg_rdata, d);
            end
        end
        // advance the model to the state after the coming edge
        if (e_cpu || e_dbg) begin
            if (e_wr) ref_mem[e_addr] = e_wdata;
            else exp_q.push_back(ref_mem[e_addr]);
        end
        m_tag   = (e_cpu && !cpu_wr) ? 1 : ((e_dbg && !dbg_wr) ? 2 : 0);
        m_owner = e_cpu ? 1 : (e_dbg ? 2 : 0);
        if (dbg_req && !e_dbg && !dbg_lock)
            m_denied = (m_denied + 1 > STARVE_MAX) ? STARVE_MAX : m_denied + 1;
        else
            m_denied = 0;
        m_last = e_addr;
        g_cpu = e_cpu; g_dbg = e_dbg;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cycle_check();
        advance();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cpu(input bit req, input bit wr, input logic [D_ADDR_W-1:0] a,
                             input logic [WIDTH-1:0] wd);
        cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    endtask

    task automatic drive_dbg(input bit req, input bit wr, input logic [D_ADDR_W-1:0] a,
                             input logic [WIDTH-1:0] wd);
        dbg_req = req; dbg_wr = wr; dbg_addr = a; dbg_wdata = wd;
    endtask

    task automatic preload(input logic [D_ADDR_W-1:0] a, input logic [WIDTH-1:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit exp_dbg;
        int p_cpu, p_dbg;
        total = 0; bad = 0;
        m_denied = 0; m_owner = 0; m_tag = 0; m_last = '0;
        g_cpu = 0; g_dbg = 0;
        for (int i = 0; i < 256; i++) preload(i[D_ADDR_W-1:0], WIDTH'($urandom));
        reset_n = 1'b0; dbg_lock = 1'b0;
        drive_cpu(0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // CPU read of 0xBEEF at 0x10
        preload(8'h10, 16'hBEEF);
        drive_cpu(1, 0, 8'h10, '0);
        cycle_check();
        chk("t1_cpu_gnt", cpu_gnt, 1);
        advance();
        drive_cpu(0, 0, 8'h10, '0);
        cycle_check();
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("t1_dbg_rvalid", dbg_rvalid, 0);
        advance();

        // debug write then CPU read of the same word
        drive_dbg(1, 1, 8'h20, 16'h1234);
        cycle_check();
        chk("t2_dbg_gnt", dbg_gnt, 1);
        advance();
        drive_dbg(0, 0, 8'h20, '0);
        drive_cpu(1, 0, 8'h20, '0);
        step();
        drive_cpu(0, 0, 8'h20, '0);
        cycle_check();
        chk("t2_cpu_rvalid", cpu_rvalid, 1);
        chk("t2_cpu_rdata", cpu_rdata, 16'h1234);
        advance();

        // both requesting continuously: CPU x4 then DBG x1
        drive_cpu(1, 0, 8'h01, '0);
        drive_dbg(1, 0, 8'h02, '0);
        for (int i = 0; i < 15; i++) begin
            cycle_check();
            exp_dbg = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
            chk("t3_dbg_gnt", dbg_gnt, exp_dbg);
            chk("t3_cpu_gnt", cpu_gnt, !exp_dbg);
            advance();
        end
        drive_cpu(0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        step();

        // debug drops after 2 denials: counter restarts
        drive_cpu(1, 1, 8'h40, 16'h0A0A);
        drive_dbg(1, 0, 8'h41, '0);
        for (int i = 0; i < 2; i++) begin
            cycle_check();
            chk("t4_early_cpu_gnt", cpu_gnt, 1);
            advance();
        end
        drive_dbg(0, 0, 8'h41, '0);
        step();
        drive_dbg(1, 0, 8'h41, '0);
        for (int i = 0; i < 5; i++) begin
            cycle_check();
            chk("t4_dbg_gnt", dbg_gnt, i == 4);
            advance();
        end
        drive_cpu(0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        step();

        // reset right after a debug read grant drops the pending rvalid
        drive_dbg(1, 0, 8'h30, '0);
        cycle_check();
        chk("t5_dbg_gnt", dbg_gnt, 1);
        advance();
        drive_dbg(0, 0, '0, '0);
        reset_n = 1'b0;
        cycle_check();
        chk("t5_dbg_rvalid_rst", dbg_rvalid, 0);
        advance();
        reset_n = 1'b1;
        cycle_check();
        chk("t5_dbg_rvalid_after", dbg_rvalid, 0);
        chk("t5_owner_after", owner, 0);
        advance();

`ifdef DMEM_ARB_LOCK_EN
        dbg_lock = 1'b1;
        drive_cpu(1, 0, 8'h05, '0);
        drive_dbg(1, 1, 8'h06, 16'h5555);
        for (int i = 0; i < 8; i++) begin
            cycle_check();
            chk("t6_dbg_gnt", dbg_gnt, 1);
            chk("t6_cpu_gnt", cpu_gnt, 0);
            advance();
        end
        dbg_lock = 1'b0;
        drive_cpu(0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        step();
`endif

        // randomized traffic with occasional resets
        p_cpu = 60; p_dbg = 40;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 500) == 0) begin
                p_cpu = $urandom_range(20, 95);
                p_dbg = $urandom_range(20, 95);
            end
            cycle_check();
            advance();
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
            end
            if (!cpu_req || g_cpu)
                drive_cpu($urandom_range(0, 99) < p_cpu, $urandom_range(0, 1) == 1,
                          D_ADDR_W'($urandom_range(0, 15)), WIDTH'($urandom));
            if (!dbg_req || g_dbg)
                drive_dbg($urandom_range(0, 99) < p_dbg, $urandom_range(0, 1) == 1,
                          D_ADDR_W'($urandom_range(0, 15)), WIDTH'($urandom));
        end
        reset_n = 1'b1;
        drive_cpu(0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port synchronous data memory. Shares the memory between the CPU datapath (driven by the instruction controller's `D_addr`/`D_wr`) and a debug/loader port used to preload or inspect data memory. One access is issued per cycle. Read data returns one cycle after grant, tagged to the owning requester. CPU has fixed priority, bounded by a starvation limit for the debug port.

## Interface
- `WIDTH`, 16: data word width
- `D_ADDR_W`, 8: data memory address width
- `STARVE_MAX`, 4: consecutive denied debug cycles before debug wins a conflict (1..15)

Ports:
- `clk`  in  1: single clock, rising edge
- `reset_n`  in  1: asynchronous, active-low reset
- `cpu_req`, `cpu_wr`  in  1: CPU access request; write when 1
- `cpu_addr`  in  D_ADDR_W: CPU address
- `cpu_wdata`  in  WIDTH: CPU write data
- `cpu_gnt`  out  1: CPU access issued this cycle
- `cpu_rvalid`  out  1: `cpu_rdata` valid, one cycle after CPU read grant
- `cpu_rdata`  out  WIDTH: read data
- `dbg_req`, `dbg_wr`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as CPU set, debug side
- `mem_addr`  out  D_ADDR_W, `mem_wr`  out  1, `mem_wdata`  out  WIDTH: to memory
- `mem_rdata`  in  WIDTH: memory output, valid cycle after address
- `owner`  out  2: last-granted requester (0 none, 1 CPU, 2 debug)

## Operation
- Grant is combinational from current requests and registered arbitration state. Granted port's addr/wr/wdata are muxed to `mem_*`.
- Arbitration each cycle:
  - neither requests: no grant, `mem_wr`=0, `mem_addr` holds last value.
  - only one requests: that one is granted.
  - both request: CPU wins unless `starve_cnt` == `STARVE_MAX`, then debug wins.
- `starve_cnt`: increments (saturating at `STARVE_MAX`) when `dbg_req` is high and not granted. Clears on debug grant or `dbg_req` low.
- Requester holds req/addr/wr/wdata stable until its `gnt` is sampled high. Grant means the access completes at that edge.
- Read tag register: on a read grant, records the owner. Next cycle it asserts that port's `rvalid` for exactly one cycle. Both `*_rdata` are wired to `mem_rdata` and are only meaningful with `rvalid`.
- Arbitration state (`owner`) values: NONE, CPU, DBG. Transitions to the granted port each cycle and to NONE on a no-grant cycle.

## Timing
- Reset values: `starve_cnt`=0, `owner`=NONE, both `rvalid`=0.
- While `reset_n`=0: both `gnt`=0, `mem_wr`=0, and all registers are held at reset values.
- Read latency: grant in cycle N, `rvalid` and data in cycle N+1. Back-to-back reads give one result per cycle.
- Write: takes effect at the granted edge. No `rvalid` is produced.
- Reset asserted mid-read: the pending `rvalid` is dropped and is not reissued after release.
- With debug continuously requesting and the CPU continuously requesting, debug is granted exactly once every `STARVE_MAX`+1 cycles.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - Adds input `dbg_lock` (1 bit).
  - While `dbg_lock`=1, `cpu_gnt` is forced 0 and debug is granted whenever it requests, for bulk memory load while the CPU is stalled.
  - `starve_cnt` held at 0 while locked.
- Macro undefined: the port is absent and arbitration is as above.

## Structure
- Shared package `dmem_pkg`: `owner_t` enum (NONE, CPU, DBG) and the default `WIDTH`/`D_ADDR_W` constants shared with the data memory and the instruction controller.
- One sub-module, `starve_counter`: saturating counter with clear and increment, parameterised by `STARVE_MAX`.
- The rest is flat: grant logic, mux, tag register.

## Test plan
- Reset, then CPU reads addr 0x10 holding 0xBEEF: `cpu_gnt` in the same cycle, next cycle `cpu_rvalid`=1 and `cpu_rdata`=0xBEEF, `dbg_rvalid`=0.
- Debug writes 0x1234 to 0x20, then CPU reads 0x20: CPU read returns 0x1234.
- Both request continuously with `STARVE_MAX`=4: grant pattern is CPU×4 then DBG×1, repeating. `starve_cnt` peaks at 4.
- Debug request dropped after 2 denied cycles, then re-raised: counter restarts from 0, so 4 more CPU wins occur before debug is granted.
- `reset_n` pulled low the cycle after a debug read grant: `dbg_rvalid` stays 0 and `owner`=NONE after release.
- With `DMEM_ARB_LOCK_EN` and `dbg_lock`=1, both requesting for 8 cycles: debug granted all 8, `cpu_gnt`=0 throughout.
